// File: rtl/alu_seq_divider_if.sv
// Handshake and result bundle between the requester and the sequential divider.
// The requester issues operands on the master side; the divider returns results on the slave side.
interface alu_seq_divider_if #(
   parameter int WIDTH = 32
);
   logic             start;
   logic [WIDTH-1:0] in1;
   logic [WIDTH-1:0] in2;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] quotient;
   logic [WIDTH-1:0] remainder;
   logic             div_by_zero;
   logic [3:0]       flags;

   modport master (
      output start, in1, in2,
      input  busy, done, quotient, remainder, div_by_zero, flags
   );

   modport slave (
      input  start, in1, in2,
      output busy, done, quotient, remainder, div_by_zero, flags
   );
endinterface

// File: rtl/alu_seq_divider.sv
// Radix-2 restoring unsigned divider that produces one quotient bit per clock.
// Results are registered separately from the working shift registers and are held until the next completion.
module alu_seq_divider #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
) (
   input logic              i_clk,
   input logic              i_reset,
   alu_seq_divider_if.slave bus
);
   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t           r_state;
   logic [WIDTH-1:0] r_rem;
   logic [WIDTH-1:0] r_q;
   logic [WIDTH-1:0] r_div;
   logic [CNT_W-1:0] r_cnt;
   logic             r_dbz_run;

   logic [WIDTH:0]   w_rem_sh;
   logic             w_ge;
   logic [WIDTH-1:0] w_diff;
   logic [WIDTH-1:0] w_rem_nx;
   logic [WIDTH-1:0] w_q_nx;

   // The shifted partial remainder needs WIDTH+1 bits. A successful subtract
   // always leaves a value below the divisor, so WIDTH bits are enough to hold it.
   assign w_rem_sh = {r_rem, r_q[WIDTH-1]};
   assign w_ge     = (w_rem_sh >= {1'b0, r_div});
   assign w_diff   = w_rem_sh[WIDTH-1:0] - r_div;
   assign w_rem_nx = w_ge ? w_diff : w_rem_sh[WIDTH-1:0];
   assign w_q_nx   = {r_q[WIDTH-2:0], w_ge};

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state         <= S_IDLE;
         r_rem           <= '0;
         r_q             <= '0;
         r_div           <= '0;
         r_cnt           <= '0;
         r_dbz_run       <= 1'b0;
         bus.busy        <= 1'b0;
         bus.done        <= 1'b0;
         bus.quotient    <= '0;
         bus.remainder   <= '0;
         bus.div_by_zero <= 1'b0;
         bus.flags       <= 4'b0000;
      end else begin
         bus.done <= 1'b0;
         case (r_state)
            S_IDLE, S_DONE: begin
               if (bus.start) begin
                  r_state <= S_RUN;
                  r_div   <= bus.in2;
                  r_rem   <= '0;
                  r_q     <= bus.in1;
                  // A zero divisor takes one wait cycle with busy low so that
                  // done lands two cycles after start.
                  if (bus.in2 == '0) begin
                     r_dbz_run <= 1'b1;
                     r_cnt     <= CNT_W'(1);
                     bus.busy  <= 1'b0;
                  end else begin
                     r_dbz_run <= 1'b0;
                     r_cnt     <= CNT_W'(WIDTH);
                     bus.busy  <= 1'b1;
                  end
               end else begin
                  r_state <= S_IDLE;
               end
            end
            S_RUN: begin
               if (!r_dbz_run) begin
                  r_rem <= w_rem_nx;
                  r_q   <= w_q_nx;
               end
               r_cnt <= r_cnt - CNT_W'(1);
               if (r_cnt == CNT_W'(1)) begin
                  r_state  <= S_DONE;
                  bus.busy <= 1'b0;
                  bus.done <= 1'b1;
                  if (r_dbz_run) begin
                     bus.quotient    <= '1;
                     bus.remainder   <= r_q;
                     bus.div_by_zero <= 1'b1;
                     bus.flags       <= 4'b1001;
                  end else begin
                     bus.quotient    <= w_q_nx;
                     bus.remainder   <= w_rem_nx;
                     bus.div_by_zero <= 1'b0;
                     bus.flags       <= {w_q_nx[WIDTH-1], (w_q_nx == '0), 1'b0, 1'b0};
                  end
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end
endmodule
